// File: rtl/fpres_retire_buffer.sv
// In-order retire FIFO between FPU post-processing and register writeback.
// Stores NaN-boxed results and flags, and ORs retired flags into fflags. Optional: FPRES_BYPASS_EN.
module fpres_retire_buffer #(
    parameter int FLEN  = 64,
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [FLEN-1:0] PostProcRes,
    input  logic [4:0]      PostProcFlg,
    input  logic [XLEN-1:0] FCvtIntRes,
    input  logic [1:0]      InFmt,
    input  logic            InToInt,
    input  logic            InFlgEn,
    input  logic [4:0]      InRd,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [FLEN-1:0] OutFRes,
    output logic [XLEN-1:0] OutIRes,
    output logic            OutToInt,
    output logic [4:0]      OutRd,
    input  logic            FFlagsWe,
    input  logic [4:0]      FFlagsWData,
    output logic [4:0]      FFlags
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [1:0] FMT_S = 2'b00;
    localparam logic [1:0] FMT_H = 2'b10;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    fflags_q, fflags_d;

    logic [FLEN-1:0] fres_mem  [DEPTH];
    logic [XLEN-1:0] ires_mem  [DEPTH];
    logic [4:0]      flg_mem   [DEPTH];
    logic [4:0]      rd_mem    [DEPTH];
    logic            toint_mem [DEPTH];
    logic            flgen_mem [DEPTH];

    logic [FLEN-1:0] in_fres_boxed;
    logic            stored_valid;
    logic            bypass;
    logic            enq;
    logic            deq;
    logic            retire;
    logic [4:0]      ret_flg;
    logic            ret_flgen;

    logic [FLEN-1:0] head_fres;
    logic [XLEN-1:0] head_ires;
    logic [4:0]      head_flg;
    logic [4:0]      head_rd;
    logic            head_toint;
    logic            head_flgen;

    // Upper bits are forced to ones for narrow formats; reserved 11 behaves as double.
    genvar gi;
    generate
        for (gi = 0; gi < FLEN; gi++) begin : g_box
            assign in_fres_boxed[gi] =
                ((InFmt == FMT_S) && (gi >= 32)) || ((InFmt == FMT_H) && (gi >= 16))
                ? 1'b1 : PostProcRes[gi];
        end
    endgenerate

    assign head_fres  = fres_mem[rd_ptr_q];
    assign head_ires  = ires_mem[rd_ptr_q];
    assign head_flg   = flg_mem[rd_ptr_q];
    assign head_rd    = rd_mem[rd_ptr_q];
    assign head_toint = toint_mem[rd_ptr_q];
    assign head_flgen = flgen_mem[rd_ptr_q];

    assign stored_valid = (count_q != '0);
    assign InReady      = (count_q != FULL_CNT);

`ifdef FPRES_BYPASS_EN
    // Empty buffer and a ready consumer: forward the input and retire it this cycle.
    assign bypass    = !stored_valid && InValid && OutReady && !Flush;
    assign OutValid  = stored_valid || bypass;
    assign OutFRes   = bypass ? in_fres_boxed : head_fres;
    assign OutIRes   = bypass ? FCvtIntRes    : head_ires;
    assign OutToInt  = bypass ? InToInt       : head_toint;
    assign OutRd     = bypass ? InRd          : head_rd;
    assign ret_flg   = bypass ? PostProcFlg   : head_flg;
    assign ret_flgen = bypass ? InFlgEn       : head_flgen;
`else
    assign bypass    = 1'b0;
    assign OutValid  = stored_valid;
    assign OutFRes   = head_fres;
    assign OutIRes   = head_ires;
    assign OutToInt  = head_toint;
    assign OutRd     = head_rd;
    assign ret_flg   = head_flg;
    assign ret_flgen = head_flgen;
`endif

    assign enq    = InValid && InReady && !Flush && !bypass;
    assign deq    = stored_valid && OutReady && !Flush;
    assign retire = OutValid && OutReady && !Flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A CSR write and a retire in the same cycle merge; Flush leaves fflags alone.
    always_comb begin
        fflags_d = FFlagsWe ? FFlagsWData : fflags_q;
        if (retire && ret_flgen) begin
            fflags_d = fflags_d | ret_flg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            fres_mem[wr_ptr_q]  <= in_fres_boxed;
            ires_mem[wr_ptr_q]  <= FCvtIntRes;
            flg_mem[wr_ptr_q]   <= PostProcFlg;
            rd_mem[wr_ptr_q]    <= InRd;
            toint_mem[wr_ptr_q] <= InToInt;
            flgen_mem[wr_ptr_q] <= InFlgEn;
        end
    end

    assign FFlags = fflags_q;

endmodule

// File: tb/tb_fpres_retire_buffer.sv
// Directed bench for fpres_retire_buffer (FLEN=XLEN=64, DEPTH=2).
// Covers boxing, backpressure, flag accumulation, CSR merge, flush, reset and the optional bypass.
module tb_fpres_retire_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [63:0] PostProcRes;
    logic [4:0]  PostProcFlg;
    logic [63:0] FCvtIntRes;
    logic [1:0]  InFmt;
    logic        InToInt;
    logic        InFlgEn;
    logic [4:0]  InRd;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] OutFRes;
    logic [63:0] OutIRes;
    logic        OutToInt;
    logic [4:0]  OutRd;
    logic        FFlagsWe;
    logic [4:0]  FFlagsWData;
    logic [4:0]  FFlags;

    int n_cmp = 0;
    int n_bad = 0;

    fpres_retire_buffer #(.FLEN(64), .XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .Flush(Flush),
        .InValid(InValid), .InReady(InReady),
        .PostProcRes(PostProcRes), .PostProcFlg(PostProcFlg), .FCvtIntRes(FCvtIntRes),
        .InFmt(InFmt), .InToInt(InToInt), .InFlgEn(InFlgEn), .InRd(InRd),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutFRes(OutFRes), .OutIRes(OutIRes), .OutToInt(OutToInt), .OutRd(OutRd),
        .FFlagsWe(FFlagsWe), .FFlagsWData(FFlagsWData), .FFlags(FFlags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] rd, input logic [63:0] res, input logic [1:0] fmt,
                       input logic [4:0] flg, input logic flgen, input logic toint,
                       input logic [63:0] ires);
        InValid     = 1'b1;
        InRd        = rd;
        PostProcRes = res;
        InFmt       = fmt;
        PostProcFlg = flg;
        InFlgEn     = flgen;
        InToInt     = toint;
        FCvtIntRes  = ires;
    endtask

    logic [63:0] vec_res [5];
    logic [1:0]  vec_fmt [5];
    logic [63:0] vec_exp [5];

    initial begin
        vec_res[0] = 64'h0000_0000_3F80_0000; vec_fmt[0] = 2'b00; vec_exp[0] = 64'hFFFF_FFFF_3F80_0000;
        vec_res[1] = 64'h0000_0000_0000_3C00; vec_fmt[1] = 2'b10; vec_exp[1] = 64'hFFFF_FFFF_FFFF_3C00;
        vec_res[2] = 64'h4009_21FB_5444_2D18; vec_fmt[2] = 2'b01; vec_exp[2] = 64'h4009_21FB_5444_2D18;
        vec_res[3] = 64'h0123_4567_89AB_CDEF; vec_fmt[3] = 2'b11; vec_exp[3] = 64'h0123_4567_89AB_CDEF;
        vec_res[4] = 64'h1234_5678_4049_0FDB; vec_fmt[4] = 2'b00; vec_exp[4] = 64'hFFFF_FFFF_4049_0FDB;

        reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        PostProcRes = '0; PostProcFlg = '0; FCvtIntRes = '0; InFmt = '0;
        InToInt = 1'b0; InFlgEn = 1'b0; InRd = '0; FFlagsWe = 1'b0; FFlagsWData = '0;
        tick(); tick();
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_inready", 64'(InReady), 64'd1);
        chk("rst_fflags", 64'(FFlags), 64'd0);
        reset = 1'b0;

        // NaN-boxing and payload per format
        for (int i = 0; i < 5; i++) begin
            OutReady = 1'b0;
            put(5'(i + 1), vec_res[i], vec_fmt[i], 5'd0, 1'b0, 1'(i), 64'(i) * 64'h111);
            tick();
            InValid = 1'b0; OutReady = 1'b1; #1;
            chk($sformatf("box%0d_valid", i), 64'(OutValid), 64'd1);
            chk($sformatf("box%0d_fres", i), OutFRes, vec_exp[i]);
            chk($sformatf("box%0d_rd", i), 64'(OutRd), 64'(i + 1));
            chk($sformatf("box%0d_toint", i), 64'(OutToInt), 64'(i % 2));
            chk($sformatf("box%0d_ires", i), OutIRes, 64'(i) * 64'h111);
            tick();
            chk($sformatf("box%0d_drained", i), 64'(OutValid), 64'd0);
        end

        // Backpressure: third entry is held off while full
        OutReady = 1'b0;
        put(5'd1, 64'h1, 2'b01, 5'd0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("bp_ready_after1", 64'(InReady), 64'd1);
        put(5'd2, 64'h2, 2'b01, 5'd0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("bp_ready_after2", 64'(InReady), 64'd0);
        put(5'd3, 64'h3, 2'b01, 5'd0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("bp_still_full", 64'(InReady), 64'd0);
        chk("bp_head1", 64'(OutRd), 64'd1);
        InValid = 1'b0; OutReady = 1'b1;
        tick();
        chk("bp_head2", 64'(OutRd), 64'd2);
        chk("bp_valid2", 64'(OutValid), 64'd1);
        chk("bp_ready_again", 64'(InReady), 64'd1);
        tick();
        chk("bp_empty", 64'(OutValid), 64'd0);
        chk("bp_empty_ready", 64'(InReady), 64'd1);

        // Simultaneous enqueue and dequeue at count 1
        OutReady = 1'b0;
        put(5'd4, 64'h4, 2'b01, 5'd0, 1'b0, 1'b0, 64'h0);
        tick();
        put(5'd5, 64'h5, 2'b01, 5'd0, 1'b0, 1'b0, 64'h0);
        OutReady = 1'b1;
        tick();
        InValid = 1'b0;
        chk("sim_head5", 64'(OutRd), 64'd5);
        chk("sim_valid", 64'(OutValid), 64'd1);
        chk("sim_ready", 64'(InReady), 64'd1);
        tick();
        chk("sim_empty", 64'(OutValid), 64'd0);

        // Flags accumulate at retire only
        OutReady = 1'b0;
        put(5'd6, 64'h6, 2'b01, 5'b00001, 1'b1, 1'b0, 64'h0);
        tick();
        put(5'd7, 64'h7, 2'b01, 5'b10000, 1'b1, 1'b0, 64'h0);
        tick();
        InValid = 1'b0;
        chk("flg_not_at_enq", 64'(FFlags), 64'd0);
        OutReady = 1'b1;
        tick();
        chk("flg_first", 64'(FFlags), 64'b00001);
        tick();
        chk("flg_second", 64'(FFlags), 64'b10001);
        OutReady = 1'b0;
        put(5'd8, 64'h8, 2'b01, 5'b00100, 1'b0, 1'b0, 64'h0);
        tick();
        InValid = 1'b0; OutReady = 1'b1;
        tick();
        chk("flg_en0_kept", 64'(FFlags), 64'b10001);
        chk("flg_en0_empty", 64'(OutValid), 64'd0);

        // CSR write merged with a retire
        OutReady = 1'b0;
        put(5'd9, 64'h9, 2'b01, 5'b00010, 1'b1, 1'b0, 64'h0);
        tick();
        InValid = 1'b0; OutReady = 1'b1; FFlagsWe = 1'b1; FFlagsWData = 5'b00000;
        tick();
        FFlagsWe = 1'b0;
        chk("csr_merge", 64'(FFlags), 64'b00010);
        chk("csr_merge_empty", 64'(OutValid), 64'd0);
        OutReady = 1'b0; FFlagsWe = 1'b1; FFlagsWData = 5'b10101;
        tick();
        FFlagsWe = 1'b0;
        chk("csr_write", 64'(FFlags), 64'b10101);

        // Flush with two buffered and an incoming entry
        put(5'd10, 64'hA, 2'b01, 5'b01000, 1'b1, 1'b0, 64'h0);
        tick();
        put(5'd11, 64'hB, 2'b01, 5'b01000, 1'b1, 1'b0, 64'h0);
        tick();
        chk("fl_full", 64'(InReady), 64'd0);
        put(5'd12, 64'hC, 2'b01, 5'b01000, 1'b1, 1'b0, 64'h0);
        Flush = 1'b1; OutReady = 1'b1;
        tick();
        Flush = 1'b0; InValid = 1'b0;
        chk("fl_outvalid", 64'(OutValid), 64'd0);
        chk("fl_inready", 64'(InReady), 64'd1);
        chk("fl_fflags", 64'(FFlags), 64'b10101);
        tick();
        chk("fl_stays_empty", 64'(OutValid), 64'd0);
        OutReady = 1'b0;
        put(5'd13, 64'hD, 2'b01, 5'b01000, 1'b1, 1'b0, 64'h0);
        tick();
        InValid = 1'b0;
        chk("fl_reuse_rd", 64'(OutRd), 64'd13);
        Flush = 1'b1; OutReady = 1'b1; FFlagsWe = 1'b1; FFlagsWData = 5'b00011;
        tick();
        Flush = 1'b0; FFlagsWe = 1'b0;
        chk("fl_csr", 64'(FFlags), 64'b00011);
        chk("fl_csr_empty", 64'(OutValid), 64'd0);

        // Reset while full overrides everything
        OutReady = 1'b0;
        put(5'd14, 64'hE, 2'b01, 5'b11111, 1'b1, 1'b0, 64'h0);
        tick();
        put(5'd15, 64'hF, 2'b01, 5'b11111, 1'b1, 1'b0, 64'h0);
        tick();
        chk("rf_full", 64'(InReady), 64'd0);
        reset = 1'b1; OutReady = 1'b1; FFlagsWe = 1'b1; FFlagsWData = 5'b11111;
        tick();
        reset = 1'b0; FFlagsWe = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        chk("rf_outvalid", 64'(OutValid), 64'd0);
        chk("rf_inready", 64'(InReady), 64'd1);
        chk("rf_fflags", 64'(FFlags), 64'd0);

        // Empty buffer with input valid and consumer ready
        OutReady = 1'b1;
        put(5'd17, 64'h0000_0000_3F80_0000, 2'b00, 5'b00001, 1'b1, 1'b0, 64'h0);
        #1;
`ifdef FPRES_BYPASS_EN
        chk("byp_valid", 64'(OutValid), 64'd1);
        chk("byp_rd", 64'(OutRd), 64'd17);
        chk("byp_fres", OutFRes, 64'hFFFF_FFFF_3F80_0000);
        tick();
        InValid = 1'b0;
        chk("byp_count0", 64'(OutValid), 64'd0);
        chk("byp_ready", 64'(InReady), 64'd1);
        chk("byp_fflags", 64'(FFlags), 64'b00001);
`else
        chk("nobyp_same_cycle", 64'(OutValid), 64'd0);
        tick();
        InValid = 1'b0;
        chk("nobyp_next_valid", 64'(OutValid), 64'd1);
        chk("nobyp_rd", 64'(OutRd), 64'd17);
        chk("nobyp_fflags_pre", 64'(FFlags), 64'd0);
        tick();
        chk("nobyp_drained", 64'(OutValid), 64'd0);
        chk("nobyp_fflags", 64'(FFlags), 64'b00001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpres_retire_buffer.md
Name: fpres_retire_buffer

Overview:
- Sits directly downstream of the FPU post-processing stage.
- Captures each FP result, integer-conversion result and 5-bit exception flag set into a small in-order FIFO.
- NaN-boxes narrow FP results to FLEN, presents entries to the register-file writeback port with a valid/ready handshake, and accumulates retired flags into the architectural fflags register.
- Decouples post-processing from writeback stalls.

Parameters:
- FLEN, 64, FP register width (32 or 64).
- XLEN, 64, integer register width.
- DEPTH, 2, FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- Flush  in  1  discard all buffered entries (pipeline flush)
- InValid  in  1  post-processor result valid
- InReady  out  1  buffer can accept
- PostProcRes  in  FLEN  FP result from post-processing
- PostProcFlg  in  5  flags {NV,DZ,OF,UF,NX}
- FCvtIntRes  in  XLEN  integer conversion result
- InFmt  in  2  result format: 00 single, 01 double, 10 half
- InToInt  in  1  result targets the integer register file
- InFlgEn  in  1  instruction updates fflags
- InRd  in  5  destination register
- OutValid  out  1  head entry valid
- OutReady  in  1  writeback accepts head
- OutFRes  out  FLEN  NaN-boxed FP result
- OutIRes  out  XLEN  integer result
- OutToInt  out  1  head targets the integer register file
- OutRd  out  5  head destination
- FFlagsWe  in  1  CSR write of fflags
- FFlagsWData  in  5  CSR write data
- FFlags  out  5  accumulated fflags

Behaviour:
- Reset: clock and reset as above (one clock, synchronous active-high reset).
  - Count, pointers and FFlags are 0.
  - OutValid=0, InReady=1.
  - Storage contents are don't-care; Out* data outputs are driven from the head slot and are don't-care while OutValid=0.
- Enqueue occurs when InValid & InReady. Dequeue (retire) occurs when OutValid & OutReady.
- InReady = (count != DEPTH). It is registered-state derived only, with no combinational path from OutReady.
- OutValid = (count != 0). Out* are taken from the head slot.
- Latency: an enqueued entry is visible at the outputs on the next cycle (1 cycle).
- Simultaneous enqueue and dequeue:
  - When full: not possible, since InReady=0.
  - When 0<count<DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- The count is log2(DEPTH)+1 bits and never exceeds DEPTH.
- NaN-boxing is applied at enqueue (stored boxed):
  - single, FLEN=64: bits[63:32] forced to all ones.
  - half: bits[FLEN-1:16] forced to all ones.
  - double: unchanged.
  - FLEN=32 with single: unchanged.
  - Reserved format 11: treated as double.
- InToInt entries still store both results; the writeback selects by OutToInt.
- Flag update on each clock (flags are accumulated at retire, not at enqueue):
  - FFlags_next = (FFlagsWe ? FFlagsWData : FFlags) | (retire & head.FlgEn ? head.Flg : 0).
  - A CSR write and a retire in the same cycle merge the two; the retired flags are never lost.
- Flush:
  - Next cycle: count=0 and pointers=0.
  - An enqueue or dequeue in the flush cycle is ignored; no flags accumulate from it.
  - A CSR write in the same cycle still takes effect.
  - FFlags itself is not cleared by Flush.
- Reset asserted mid-operation overrides Flush, enqueue, dequeue and CSR write.

Optional Feature:
- Macro: FPRES_BYPASS_EN.
- When defined: if count==0 & InValid & OutReady & ~Flush, the input is forwarded combinationally to Out* (NaN-boxed) with OutValid=1.
  - The entry retires in that same cycle with zero latency and is not written to storage.
  - Flags accumulate per the normal retire rule.
  - InReady is unchanged.
- When undefined: minimum latency is 1 cycle and there is no combinational path from In* to Out*.

Test Plan:
- Enqueue single result PostProcRes=0x0000_0000_3F80_0000, InFmt=00, OutReady=1 → next cycle OutValid=1, OutFRes=0xFFFF_FFFF_3F80_0000; half 0x3C00 → 0xFFFF_FFFF_FFFF_3C00.
- Hold OutReady=0 and enqueue 3 entries → InReady drops after the 2nd; the 3rd is held off. Release OutReady → entries drain in order by OutRd (1,2), then InReady=1.
- Retire flags 5'b00001 then 5'b10000, both with FlgEn=1 → FFlags=5'b10001. An entry with FlgEn=0 and flags 5'b00100 leaves FFlags unchanged.
- In one cycle, FFlagsWe=1 with WData=5'b00000 while retiring an entry with flags 5'b00010 → FFlags=5'b00010.
- Flush with 2 entries buffered and InValid=1 in the same cycle → next cycle OutValid=0 and count=0; FFlags retains its prior value.
- Reset asserted while full → next cycle OutValid=0, InReady=1, FFlags=0.
- With FPRES_BYPASS_EN, empty buffer, InValid=OutReady=1 → OutValid=1 in the same cycle with OutRd=InRd, and count stays 0.
